// File: rtl/monster_spawner.sv
// Frame-rate monster spawn scheduler: accumulates scroll distance, pulses gene, tracks appear, cools down.
// Define MONSTER_RANDOM_X_EN to draw spawn_x from a 10-bit LFSR instead of the fixed position.
module monster_spawner #(
    parameter logic [15:0] SPAWN_DIST     = 16'd600,
    parameter logic [7:0]  COOLDOWN       = 8'd60,
    parameter logic [9:0]  X_MIN          = 10'd170,
    parameter logic [9:0]  X_MAX          = 10'd469,
    parameter logic [9:0]  MONSTER_SIZE   = 10'd39,
    parameter logic [9:0]  SPAWN_X_FIXED  = 10'd200,
    parameter logic [9:0]  SPAWN_Y        = 10'd40,
    parameter logic [1:0]  APPEAR_TIMEOUT = 2'd3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       game_active,
    input  logic [9:0] scroll_dist,
    input  logic       appear,
    output logic       gene,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y,
    output logic [7:0] spawn_count,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ACCUM       = 3'd1;
    localparam logic [2:0] ST_ISSUE       = 3'd2;
    localparam logic [2:0] ST_WAIT_APPEAR = 3'd3;
    localparam logic [2:0] ST_LIVE        = 3'd4;
    localparam logic [2:0] ST_COOLDOWN    = 3'd5;

    localparam logic [9:0] X_HI = X_MAX - MONSTER_SIZE;

    logic [2:0]  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  tmo_q, tmo_d;
    logic [7:0]  cd_q, cd_d;
    logic [9:0]  spawn_x_q, spawn_x_d;
    logic [7:0]  count_q, count_d;

    logic [16:0] acc_sum;
    logic [15:0] acc_sat;
    logic [9:0]  next_x;

`ifdef MONSTER_RANDOM_X_EN
    logic [9:0] lfsr_q;
    logic [9:0] rand_x;

    // Free-running x^10+x^7+1 LFSR; it advances in every state so spawn positions decorrelate from timing.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= 10'h1A5;
        end else begin
            lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    assign rand_x = X_MIN + {2'b00, lfsr_q[7:0]};
    assign next_x = (rand_x > X_HI) ? X_HI : rand_x;
`else
    // An overridden fixed position is still kept on the playfield.
    assign next_x = (SPAWN_X_FIXED < X_MIN) ? X_MIN :
                    (SPAWN_X_FIXED > X_HI)  ? X_HI  : SPAWN_X_FIXED;
`endif

    assign acc_sum = {1'b0, acc_q} + {7'b0, scroll_dist};
    assign acc_sat = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        cd_d      = cd_q;
        spawn_x_d = spawn_x_q;
        count_d   = count_q;

        if (!game_active) begin
            state_d = ST_IDLE;
            acc_d   = 16'd0;
            tmo_d   = 2'd0;
            cd_d    = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_d   = 16'd0;
                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (acc_q >= SPAWN_DIST) begin
                        state_d   = ST_ISSUE;
                        spawn_x_d = next_x;
                        count_d   = count_q + 8'd1;
                    end else begin
                        acc_d = acc_sat;
                    end
                end
                ST_ISSUE: begin
                    acc_d   = 16'd0;
                    tmo_d   = APPEAR_TIMEOUT;
                    state_d = ST_WAIT_APPEAR;
                end
                ST_WAIT_APPEAR: begin
                    if (appear) begin
                        tmo_d   = 2'd0;
                        state_d = ST_LIVE;
                    end else if (tmo_q <= 2'd1) begin
                        // Lost spawn: the monster never showed, so back off exactly as if it had died.
                        tmo_d   = 2'd0;
                        cd_d    = COOLDOWN;
                        state_d = ST_COOLDOWN;
                    end else begin
                        tmo_d = tmo_q - 2'd1;
                    end
                end
                ST_LIVE: begin
                    if (!appear) begin
                        cd_d    = COOLDOWN;
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    acc_d = 16'd0;
                    if (cd_q == 8'd0) begin
                        state_d = ST_ACCUM;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = 16'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= 16'd0;
            tmo_q     <= 2'd0;
            cd_q      <= 8'd0;
            spawn_x_q <= SPAWN_X_FIXED;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            cd_q      <= cd_d;
            spawn_x_q <= spawn_x_d;
            count_q   <= count_d;
        end
    end

    // Moore outputs straight from the state register.
    assign gene        = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_APPEAR) || (state_q == ST_LIVE);
    assign spawn_x     = spawn_x_q;
    assign spawn_y     = SPAWN_Y;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_monster_spawner.sv
// Directed self-checking bench for monster_spawner; honours MONSTER_RANDOM_X_EN for spawn_x expectations.
module tb_monster_spawner;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       game_active;
    logic [9:0] scroll_dist;
    logic       appear;
    logic       gene;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic [7:0] spawn_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    monster_spawner dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .game_active (game_active),
        .scroll_dist (scroll_dist),
        .appear      (appear),
        .gene        (gene),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_count (spawn_count),
        .busy        (busy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling and driving.
    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic check_x(input string tag);
`ifdef MONSTER_RANDOM_X_EN
        check(tag, 16'((spawn_x >= 10'd170) && (spawn_x <= 10'd430)), 16'd1);
`else
        check(tag, 16'(spawn_x), 16'd200);
`endif
    endtask

    initial begin
        int w;
        logic [9:0] x_min;
        logic [9:0] x_max;

        Reset       = 1'b1;
        game_active = 1'b0;
        scroll_dist = 10'd0;
        appear      = 1'b0;
        @(negedge frame_clk);
        check("rst_gene", 16'(gene), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_count", 16'(spawn_count), 16'd0);
        check("rst_spawn_x", 16'(spawn_x), 16'd200);
        check("rst_spawn_y", 16'(spawn_y), 16'd40);
        Reset = 1'b0;
        step(1);

        // 100 px/frame: IDLE->ACCUM, six accumulations to 600, gene on the eighth edge.
        game_active = 1'b1;
        scroll_dist = 10'd100;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("accum_no_gene", 16'(gene), 16'd0);
        end
        step(1);
        check("first_gene", 16'(gene), 16'd1);
        check("first_count", 16'(spawn_count), 16'd1);
        check("first_busy", 16'(busy), 16'd1);
        check_x("first_spawn_x");
        step(1);
        check("pulse_width", 16'(gene), 16'd0);
        check("wait_busy", 16'(busy), 16'd1);

        // Monster answers one edge after gene; large scroll while LIVE must not accumulate.
        appear      = 1'b1;
        scroll_dist = 10'd1023;
        step(1);
        check("live_busy", 16'(busy), 16'd1);
        for (int i = 0; i < 19; i++) begin
            step(1);
            check("live_hold", 16'({busy, gene}), 16'b10);
        end
        appear = 1'b0;
        step(1);
        check("cooldown_busy", 16'(busy), 16'd0);
        // 60 cooldown frames + the zero frame, then one ACCUM frame to load 1023: quiet for 62 edges.
        for (int i = 0; i < 62; i++) begin
            step(1);
            check("cooldown_quiet", 16'({busy, gene}), 16'b00);
        end
        step(1);
        check("post_cd_gene", 16'(gene), 16'd1);
        check("post_cd_count", 16'(spawn_count), 16'd2);

        // No appear: three WAIT_APPEAR frames, then COOLDOWN.
        scroll_dist = 10'd0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("timeout_wait", 16'({busy, gene}), 16'b10);
        end
        step(1);
        check("timeout_to_cooldown", 16'(busy), 16'd0);

        game_active = 1'b0;
        step(1);
        check("drop_idle_busy", 16'(busy), 16'd0);

        game_active = 1'b1;
        scroll_dist = 10'd300;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("accum300_no_gene", 16'(gene), 16'd0);
        end
        step(1);
        check("third_gene", 16'(gene), 16'd1);
        check("third_count", 16'(spawn_count), 16'd3);
        step(1);
        appear = 1'b1;
        step(1);
        check("third_live", 16'(busy), 16'd1);

        // appear falls and game_active drops together: must land in IDLE, not COOLDOWN.
        appear      = 1'b0;
        game_active = 1'b0;
        step(1);
        check("drop_vs_appear_busy", 16'(busy), 16'd0);
        game_active = 1'b1;
        scroll_dist = 10'd600;
        step(1);
        check("from_idle_a", 16'(gene), 16'd0);
        step(1);
        check("from_idle_b", 16'(gene), 16'd0);
        step(1);
        check("drop_went_idle", 16'(gene), 16'd1);
        check("fourth_count", 16'(spawn_count), 16'd4);
        step(1);
        appear = 1'b1;
        step(1);
        check("fourth_live", 16'(busy), 16'd1);

        // Asynchronous reset mid-LIVE, sampled before any clock edge.
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_busy", 16'(busy), 16'd0);
        check("async_rst_gene", 16'(gene), 16'd0);
        check("async_rst_count", 16'(spawn_count), 16'd0);
        check("async_rst_spawn_x", 16'(spawn_x), 16'd200);
        @(negedge frame_clk);
        appear      = 1'b0;
        game_active = 1'b1;
        scroll_dist = 10'd1023;
        Reset       = 1'b0;

        // 50 lost-spawn cycles to exercise spawn_x.
        x_min = 10'h3FF;
        x_max = 10'd0;
        for (int s = 0; s < 50; s++) begin
            w = 0;
            while (!gene && w < 200) begin
                step(1);
                w++;
            end
            check("spawn_seen", 16'(gene), 16'd1);
            if (!gene) break;
            check_x("loop_spawn_x");
            if (spawn_x < x_min) x_min = spawn_x;
            if (spawn_x > x_max) x_max = spawn_x;
            step(1);
        end
        check("loop_count", 16'(spawn_count), 16'd50);
`ifdef MONSTER_RANDOM_X_EN
        check("spawn_x_varies", 16'(x_min != x_max), 16'd1);
`else
        check("spawn_x_constant", 16'(x_min == x_max), 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
